// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the two-requester byte-wide data memory controller.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int NUM_REQ        = 2;
    localparam int BYTES_PER_WORD = 4;

    // A word access is legal only if aligned and wholly inside the memory.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > (mem_bytes - 32'(BYTES_PER_WORD)));
    endfunction

endpackage

// File: rtl/data_mem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; ptr names the requester that wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Arbitrates word load/store requests from two requesters and sequences each
// word as four little-endian byte cycles on a synchronous byte-wide memory.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int MEM_BYTES = 32,
    parameter int MEM_AW    = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [1:0]        req_we_i,
    input  logic [63:0]       req_addr_i,
    input  logic [63:0]       req_wdata_i,
    output logic [1:0]        rsp_valid_o,
    output logic              rsp_err_o,
    output logic [31:0]       rsp_rdata_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    // Handshake: a request is accepted in the cycle where req_valid_i[n] and
    // req_ready_o[n] are both high; ready is only ever raised in IDLE.
    state_e             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               owner_q, owner_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic [MEM_AW-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic               mem_re_q, mem_re_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;

    logic [1:0]  gnt;
    logic        arb_en;
    logic [31:0] sel_addr;

    // Gating with rst_i keeps ready low while reset is held.
    assign arb_en = (state_q == IDLE) && rst_i;

    rr_arb2 u_arb (
        .req (req_valid_i),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign req_ready_o = gnt;
    assign sel_addr    = gnt[1] ? req_addr_i[63:32] : req_addr_i[31:0];

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    owner_d  = gnt[1];
                    we_d     = gnt[1] ? req_we_i[1] : req_we_i[0];
                    addr_d   = sel_addr[MEM_AW-1:0];
                    wdata_d  = gnt[1] ? req_wdata_i[63:32] : req_wdata_i[31:0];
                    rr_ptr_d = ~gnt[1];
                    err_d    = addr_bad(sel_addr, 32'(MEM_BYTES));
                    rdata_d  = 32'h0;
                    beat_d   = 2'd0;
                    state_d  = addr_bad(sel_addr, 32'(MEM_BYTES)) ? RESP : XFER;
                end
            end
            XFER: begin
                // Read data lags the strobe by one cycle, so beat n lands byte n-1.
                if (!we_q && (beat_q != 2'd0)) begin
                    rdata_d[{beat_q - 2'd1, 3'b000} +: 8] = mem_rdata_i;
                end
                if (beat_q == 2'd3) begin
                    state_d = we_q ? RESP : DRAIN;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            DRAIN: begin
                rdata_d[31:24] = mem_rdata_i;
                state_d        = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_wdata_d = 8'h00;
        if (state_d == XFER) begin
            mem_addr_d  = addr_d + {{(MEM_AW-2){1'b0}}, beat_d};
            mem_we_d    = we_d;
            mem_re_d    = !we_d;
            mem_wdata_d = we_d ? wdata_d[{beat_d, 3'b000} +: 8] : 8'h00;
        end

        rsp_valid_d = 2'b00;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        if (state_d == RESP) begin
            rsp_valid_d = owner_d ? 2'b10 : 2'b01;
            rsp_err_d   = err_d;
            rsp_rdata_d = (err_d || we_d) ? 32'h0 : rdata_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            rr_ptr_q    <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte memory model, word-level reference memory,
// round-robin priority model and per-cycle strobe/response timing checks.
module tb_data_mem_ctrl;

    localparam int MEM_BYTES = 32;
    localparam int MEM_AW    = 5;

    logic              clk;
    logic              rst_i;
    logic [1:0]        req_valid_i;
    logic [1:0]        req_ready_o;
    logic [1:0]        req_we_i;
    logic [63:0]       req_addr_i;
    logic [63:0]       req_wdata_i;
    logic [1:0]        rsp_valid_o;
    logic              rsp_err_o;
    logic [31:0]       rsp_rdata_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic              mem_we_o;
    logic              mem_re_o;
    logic [7:0]        mem_wdata_o;
    logic [7:0]        mem_rdata_i;

    data_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .MEM_AW(MEM_AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_rdata_o (rsp_rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_re_o    (mem_re_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory device and reference ----------------
    logic [7:0]  dev_mem [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        init_mem;
    logic [31:0] exp_q [$];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < MEM_BYTES; i++) dev_mem[i] <= 8'h00;
        end else begin
            if (mem_we_o) dev_mem[mem_addr_o] <= mem_wdata_o;
            if (mem_re_o) mem_rdata_i <= dev_mem[mem_addr_o];
        end
    end

    int          n_checks;
    int          n_errors;
    int          prio;
    logic        f_we    [2];
    logic [31:0] f_addr  [2];
    logic [31:0] f_wdata [2];

    function automatic logic [51:0] all_out();
        return {req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
                mem_addr_o, mem_we_o, mem_re_o, mem_wdata_o};
    endfunction

    task automatic drive_fields();
        req_we_i    = {f_we[1], f_we[0]};
        req_addr_i  = {f_addr[1], f_addr[0]};
        req_wdata_i = {f_wdata[1], f_wdata[0]};
    endtask

    task automatic gen_fields(input int r);
        f_we[r]    = 1'($urandom_range(0, 1));
        f_wdata[r] = $urandom;
        if ($urandom_range(0, 7) == 0) f_addr[r] = 32'($urandom_range(0, 40));
        else                           f_addr[r] = 32'($urandom_range(0, 7) * 4);
    endtask

    // ---------------- driver + per-cycle checks for one transaction ----------------
    task automatic run_txn(input logic [1:0] vmask, output int g);
        logic        e;
        logic [31:0] a;
        logic [31:0] exp_rd;
        logic [31:0] wsh;
        logic [4:0]  exp_addr;
        logic        exp_we, exp_re;
        logic [1:0]  exp_v;
        int          rsp_k;
        @(negedge clk);
        drive_fields();
        req_valid_i = vmask;
        #1;
        g = (vmask == 2'b11) ? prio : (vmask[1] ? 1 : 0);
        n_checks++;
        if (req_ready_o !== (2'b01 << g)) begin
            n_errors++;
            $display("FAIL grant: ready=%b expected=%b (valid=%b)", req_ready_o, 2'b01 << g, vmask);
        end
        prio = 1 - g;
        a = f_addr[g];
        e = (a[1:0] != 2'b00) || (a > 32'(MEM_BYTES - 4));
        exp_rd = 32'h0;
        if (!e && !f_we[g]) exp_rd = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        if (!e && f_we[g]) begin
            for (int i = 0; i < 4; i++) ref_mem[a+i] = f_wdata[g][8*i +: 8];
        end
        exp_q.push_back(exp_rd);
        rsp_k = e ? 1 : (f_we[g] ? 5 : 6);
        for (int k = 1; k <= rsp_k; k++) begin
            @(negedge clk);
            if (k == 1) req_valid_i[g] = 1'b0;
            #1;
            exp_we = !e && f_we[g] && (k <= 4);
            exp_re = !e && !f_we[g] && (k <= 4);
            n_checks++;
            if ({mem_we_o, mem_re_o} !== {exp_we, exp_re}) begin
                n_errors++;
                $display("FAIL strobe k=%0d: we/re=%b%b expected=%b%b", k, mem_we_o, mem_re_o, exp_we, exp_re);
            end
            if (exp_we || exp_re) begin
                exp_addr = a[4:0] + 5'(k - 1);
                n_checks++;
                if (mem_addr_o !== exp_addr) begin
                    n_errors++;
                    $display("FAIL mem_addr k=%0d: got %0d expected %0d", k, mem_addr_o, exp_addr);
                end
            end
            if (exp_we) begin
                wsh = f_wdata[g] >> (8 * (k - 1));
                n_checks++;
                if (mem_wdata_o !== wsh[7:0]) begin
                    n_errors++;
                    $display("FAIL mem_wdata k=%0d: got %h expected %h", k, mem_wdata_o, wsh[7:0]);
                end
            end
            n_checks++;
            if (req_ready_o !== 2'b00) begin
                n_errors++;
                $display("FAIL ready_busy k=%0d: got %b expected 00", k, req_ready_o);
            end
            exp_v = (k == rsp_k) ? (2'b01 << g) : 2'b00;
            n_checks++;
            if (rsp_valid_o !== exp_v) begin
                n_errors++;
                $display("FAIL rsp_valid k=%0d: got %b expected %b", k, rsp_valid_o, exp_v);
            end
            if (k == rsp_k) begin
                exp_rd = exp_q.pop_front();
                n_checks++;
                if ({rsp_err_o, rsp_rdata_o} !== {e, exp_rd}) begin
                    n_errors++;
                    $display("FAIL rsp_data addr=%0d we=%b: err=%b rdata=%h expected err=%b rdata=%h",
                             a, f_we[g], rsp_err_o, rsp_rdata_o, e, exp_rd);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i       = 1'b0;
        init_mem    = 1'b1;
        req_valid_i = 2'b11;
        req_we_i    = 2'b00;
        req_addr_i  = 64'h0;
        req_wdata_i = 64'h0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        prio = 0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (all_out() !== 52'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out());
        end
        req_valid_i = 2'b00;
        init_mem    = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (all_out() !== 52'h0) begin
            n_errors++;
            $display("FAIL idle_outputs: got %h expected 0", all_out());
        end
    endtask

    task automatic test_arbitration();
        int g;
        f_we[0] = 1'b1; f_addr[0] = 32'd0;  f_wdata[0] = 32'hA5A55A5A;
        f_we[1] = 1'b1; f_addr[1] = 32'd4;  f_wdata[1] = 32'h11223344;
        run_txn(2'b11, g);
        run_txn(2'b10, g);
        f_wdata[1] = 32'h55667788;
        run_txn(2'b11, g);
        run_txn(2'b10, g);
    endtask

    task automatic test_store_load();
        int g;
        f_we[0] = 1'b1; f_addr[0] = 32'd8; f_wdata[0] = 32'hDEADBEEF;
        run_txn(2'b01, g);
        f_we[0] = 1'b0;
        run_txn(2'b01, g);
    endtask

    task automatic test_errors();
        int g;
        f_we[0] = 1'b0; f_addr[0] = 32'd6;
        run_txn(2'b01, g);
        f_addr[0] = 32'd32;
        run_txn(2'b01, g);
        f_we[1] = 1'b1; f_addr[1] = 32'hFFFF_FFFC; f_wdata[1] = 32'hCAFEF00D;
        run_txn(2'b10, g);
    endtask

    task automatic test_last_word();
        int g;
        f_we[1] = 1'b1; f_addr[1] = 32'd28; f_wdata[1] = 32'h01020304;
        run_txn(2'b10, g);
        f_we[1] = 1'b0;
        run_txn(2'b10, g);
    endtask

    task automatic test_reset_mid();
        int g;
        @(negedge clk);
        f_we[0] = 1'b0; f_addr[0] = 32'd8;
        drive_fields();
        req_valid_i = 2'b01;
        #1;
        n_checks++;
        if (req_ready_o !== 2'b01) begin
            n_errors++;
            $display("FAIL mid_grant: ready=%b expected 01", req_ready_o);
        end
        @(negedge clk);
        req_valid_i = 2'b00;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (all_out() !== 52'h0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: got %h expected 0", all_out());
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (all_out() !== 52'h0) begin
            n_errors++;
            $display("FAIL mid_reset_hold: got %h expected 0", all_out());
        end
        rst_i = 1'b1;
        prio  = 0;
        @(negedge clk);
        #1;
        n_checks++;
        if (rsp_valid_o !== 2'b00) begin
            n_errors++;
            $display("FAIL mid_reset_no_rsp: rsp_valid=%b expected 00", rsp_valid_o);
        end
        run_txn(2'b01, g);
    endtask

    task automatic test_random();
        int         g;
        logic [1:0] pend;
        pend = 2'b00;
        repeat (60) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 2) != 0)) begin
                    pend[r] = 1'b1;
                    gen_fields(r);
                end
            end
            if (pend == 2'b00) begin
                pend[0] = 1'b1;
                gen_fields(0);
            end
            run_txn(pend, g);
            pend[g] = 1'b0;
        end
        while (pend != 2'b00) begin
            run_txn(pend, g);
            pend[g] = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_arbitration();
        test_store_load();
        test_errors();
        test_last_word();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
